// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests, one-entry skid buffer, branch redirect.
// Optional sticky misaligned-redirect flag enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_en,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        fd_valid,
  output logic        fetch_misalign
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StFull} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_pc, w_pc_d;
  logic [31:0] r_req_pc, w_req_pc_d;
  logic        r_kill, w_kill_d;
  logic [31:0] r_buf_pc, w_buf_pc_d;
  logic [31:0] r_buf_instr, w_buf_instr_d;
  logic [31:0] r_fd_pc, r_fd_instr;
  logic        r_fd_valid;

  logic        w_deliver;
  logic [31:0] w_deliver_pc, w_deliver_instr;
  logic [31:0] w_target;

  assign w_target = {br_target[31:2], 2'b00};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_pc_d          = r_pc;
    w_req_pc_d      = r_req_pc;
    w_kill_d        = r_kill;
    w_buf_pc_d      = r_buf_pc;
    w_buf_instr_d   = r_buf_instr;
    w_deliver       = 1'b0;
    w_deliver_pc    = r_req_pc;
    w_deliver_instr = imem_rdata;
    unique case (r_state)
      StIdle: w_state_d = StReq;
      StReq: begin
        if (imem_gnt) begin
          w_req_pc_d = r_pc;
          w_pc_d     = r_pc + 32'd4;
          w_state_d  = StWait;
        end
      end
      StWait: begin
        if (imem_rvalid) begin
          if (r_kill) begin
            w_kill_d  = 1'b0;
            w_state_d = StReq;
          end else if (!stall) begin
            w_deliver = 1'b1;
            w_state_d = StReq;
          end else begin
            w_buf_pc_d    = r_req_pc;
            w_buf_instr_d = imem_rdata;
            w_state_d     = StFull;
          end
        end
      end
      StFull: begin
        if (!stall) begin
          w_deliver       = 1'b1;
          w_deliver_pc    = r_buf_pc;
          w_deliver_instr = r_buf_instr;
          w_state_d       = StReq;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Redirect overrides everything; an in-flight or just-granted request must be drained and killed.
    if (br_en) begin
      w_pc_d = w_target;
      if ((r_state == StWait && !imem_rvalid) || (r_state == StReq && imem_gnt)) begin
        w_kill_d  = 1'b1;
        w_state_d = StWait;
      end else begin
        w_kill_d  = 1'b0;
        w_state_d = StReq;
      end
    end
  end

  always_comb begin
    imem_req  = (r_state == StReq);
    imem_addr = r_pc;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= 32'h0;
      r_kill      <= 1'b0;
      r_buf_pc    <= 32'h0;
      r_buf_instr <= 32'h0;
      r_fd_pc     <= 32'h0;
      r_fd_instr  <= 32'h0;
      r_fd_valid  <= 1'b0;
    end else begin
      r_pc        <= w_pc_d;
      r_req_pc    <= w_req_pc_d;
      r_kill      <= w_kill_d;
      r_buf_pc    <= w_buf_pc_d;
      r_buf_instr <= w_buf_instr_d;
      if (br_en) begin
        r_fd_pc    <= 32'h0;
        r_fd_instr <= 32'h0;
        r_fd_valid <= 1'b0;
      end else if (!stall) begin
        r_fd_pc    <= w_deliver ? w_deliver_pc : 32'h0;
        r_fd_instr <= w_deliver ? w_deliver_instr : 32'h0;
        r_fd_valid <= w_deliver;
      end
    end
  end

  assign fd_pc    = r_fd_pc;
  assign fd_instr = r_fd_instr;
  assign fd_valid = r_fd_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (br_en && (br_target[1:0] != 2'b00)) begin
      r_misalign <= 1'b1;
    end
  end

  assign fetch_misalign = r_misalign;
`else
  logic w_unused_tgt_lsb;
  assign w_unused_tgt_lsb = ^br_target[1:0];
  assign fetch_misalign   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/skid, redirect, wrap, misalign, async reset.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        br_en;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_valid;
  logic        fetch_misalign;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_mis;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .br_en         (br_en),
    .br_target     (br_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .fd_pc         (fd_pc),
    .fd_instr      (fd_instr),
    .fd_valid      (fd_valid),
    .fetch_misalign(fetch_misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_fd(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic v);
    chk({tag, "_pc"}, fd_pc, pc);
    chk({tag, "_instr"}, fd_instr, ins);
    chk({tag, "_valid"}, {31'h0, fd_valid}, {31'h0, v});
  endtask

  initial begin
`ifdef FETCH_ALIGN_CHECK_EN
    exp_mis = 1'b1;
`else
    exp_mis = 1'b0;
`endif
    reset = 1'b0; stall = 1'b0; br_en = 1'b0; br_target = 32'h0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    chk_fd("rst_fd", 32'h0, 32'h0, 1'b0);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_mis", {31'h0, fetch_misalign}, 32'h0);
    reset = 1'b1;

    // Cycle 1: first request to RESET_PC
    tick();
    chk("c1_req", {31'h0, imem_req}, 32'h1);
    chk("c1_addr", imem_addr, 32'h100);
    tick();
    chk("c2_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
    tick();
    chk_fd("c3_fd", 32'h100, 32'h00A0_0093, 1'b1);
    chk("c3_addr", imem_addr, 32'h104);
    chk("c3_req", {31'h0, imem_req}, 32'h1);
    imem_rvalid = 1'b0;

    // Stall for three edges; response lands in the skid buffer
    stall = 1'b1;
    tick();
    chk_fd("st1", 32'h100, 32'h00A0_0093, 1'b1);
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_8133;
    tick();
    chk_fd("st2", 32'h100, 32'h00A0_0093, 1'b1);
    chk("st2_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b0;
    tick();
    chk_fd("st3", 32'h100, 32'h00A0_0093, 1'b1);
    chk("st3_req", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    tick();
    chk_fd("drain", 32'h104, 32'h0020_8133, 1'b1);
    chk("drain_addr", imem_addr, 32'h108);

    // Redirect while waiting: old-path response is discarded
    tick();
    chk_fd("bub", 32'h0, 32'h0, 1'b0);
    br_en = 1'b1; br_target = 32'h200;
    tick();
    br_en = 1'b0;
    chk_fd("br_fd", 32'h0, 32'h0, 1'b0);
    chk("br_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    chk_fd("kill_fd", 32'h0, 32'h0, 1'b0);
    chk("kill_req", {31'h0, imem_req}, 32'h1);
    chk("kill_addr", imem_addr, 32'h200);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    tick();
    imem_rvalid = 1'b0;
    chk_fd("tgt_fd", 32'h200, 32'h1111_1111, 1'b1);

    // Branch and stall together with the buffer full
    stall = 1'b1;
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    tick();
    imem_rvalid = 1'b0;
    chk("full_req", {31'h0, imem_req}, 32'h0);
    chk("full_fd", fd_instr, 32'h1111_1111);
    br_en = 1'b1; br_target = 32'h300;
    tick();
    br_en = 1'b0; stall = 1'b0;
    chk_fd("brst_fd", 32'h0, 32'h0, 1'b0);
    chk("brst_addr", imem_addr, 32'h300);
    chk("brst_req", {31'h0, imem_req}, 32'h1);
    tick();
    chk_fd("nobuf_fd", 32'h0, 32'h0, 1'b0);
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    tick();
    imem_rvalid = 1'b0;
    chk_fd("t300_fd", 32'h300, 32'h3333_3333, 1'b1);

    // Redirect coinciding with a grant, to the last word of the address space
    br_en = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_en = 1'b0;
    chk("kg_req", {31'h0, imem_req}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    tick();
    imem_rvalid = 1'b0;
    chk_fd("kg_fd", 32'h0, 32'h0, 1'b0);
    chk("kg_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    tick();
    imem_rvalid = 1'b0;
    chk_fd("wrap_fd", 32'hFFFF_FFFC, 32'h5555_5555, 1'b1);
    chk("wrap_addr", imem_addr, 32'h0);

    // Misaligned redirect in REQ without grant
    imem_gnt = 1'b0; br_en = 1'b1; br_target = 32'h202;
    tick();
    br_en = 1'b0;
    chk("mis_addr", imem_addr, 32'h200);
    chk("mis_flag", {31'h0, fetch_misalign}, {31'h0, exp_mis});
    tick();
    chk("mis_sticky", {31'h0, fetch_misalign}, {31'h0, exp_mis});
    imem_gnt = 1'b1;

    // Asynchronous reset with a request in flight
    tick();
    reset = 1'b0;
    #1;
    chk_fd("ar_fd", 32'h0, 32'h0, 1'b0);
    chk("ar_req", {31'h0, imem_req}, 32'h0);
    chk("ar_mis", {31'h0, fetch_misalign}, 32'h0);
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    #1;
    reset = 1'b1;
    tick();
    imem_rvalid = 1'b0;
    chk("ar_req2", {31'h0, imem_req}, 32'h1);
    chk("ar_addr2", imem_addr, 32'h100);
    chk_fd("ar_fd2", 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage; produces `fd_pc`/`fd_instr` for the decode stage and honours decode's `stall` and the ALU's branch redirect. Issues one outstanding request at a time to instruction memory over a request/grant + response-valid handshake. Holds a one-entry skid buffer so a response that arrives during a stall is never lost. Inserts all-zero bubbles (opcode 0: no writeback, no memory access, no branch) whenever no instruction is ready.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clock`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `stall`  in  1  decode load-use stall; fd outputs must hold
- `br_en`  in  1  branch taken; flush and redirect
- `br_target`  in  32  redirect address, valid when `br_en`=1
- `imem_req`  out  1  request valid
- `imem_addr`  out  32  request address
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid
- `imem_rdata`  in  32  response instruction word
- `fd_pc`  out  32  PC of `fd_instr` (registered)
- `fd_instr`  out  32  instruction to decode; 0 = bubble (registered)
- `fd_valid`  out  1  `fd_instr` is a real instruction (registered)
- `fetch_misalign`  out  1  sticky misaligned-redirect flag (see Configuration)

## Operation
- Registers: `pc_q` (next fetch address), `req_pc_q` (address of in-flight request), `kill_q`, skid buffer `{buf_pc, buf_instr}`, state.
- States: IDLE, REQ, WAIT, FULL. `imem_req` = (state==REQ); `imem_addr` = `pc_q`.
- IDLE → REQ unconditionally (first cycle after reset release).
- REQ: on `imem_gnt`: `req_pc_q`←`pc_q`, `pc_q`←`pc_q`+4 (mod 2^32, wraps 32'hFFFF_FFFC→0), → WAIT.
- WAIT: on `imem_rvalid`:
  - `kill_q`=1 → discard data, clear `kill_q`, → REQ.
  - `stall`=0 → fd←{`req_pc_q`, `imem_rdata`, valid=1}, → REQ.
  - `stall`=1 → buffer←{`req_pc_q`, `imem_rdata`}, → FULL.
- FULL: no request; when `stall`=0, fd←buffer (valid=1), → REQ.
- fd register update each edge: `br_en` → bubble (pc=0, instr=0, valid=0); else `stall` → hold; else load new instruction if one delivered this cycle (WAIT response or FULL drain), otherwise bubble.
- Redirect (`br_en`=1), highest priority over stall and everything else: `pc_q`←aligned `br_target`; buffer discarded; if state WAIT, or REQ with `imem_gnt`=1 this cycle → `kill_q`←1, state WAIT; if WAIT and `imem_rvalid`=1 same cycle → response discarded, → REQ, `kill_q` stays 0; IDLE/REQ(no gnt)/FULL → REQ.
- Killed grant in REQ does not advance `pc_q` past the target (target wins).
- Aligned target = {`br_target`[31:2], 2'b00}.

## Timing
- Reset (async assert): state IDLE, `pc_q`=`RESET_PC`, `kill_q`=0, `fd_pc`=0, `fd_instr`=0, `fd_valid`=0, `imem_req`=0, `fetch_misalign`=0.
- First `imem_req` in cycle 1 after reset deasserts (cycle 0 = IDLE).
- Zero-wait memory (gnt in REQ cycle, rvalid next cycle): instruction visible on fd 2 cycles after request; sustained rate 1 instruction / 2 cycles, bubble in between.
- `stall` sampled at edge; fd holds exactly while `stall`=1; buffered instruction appears on fd the cycle after `stall` falls.
- `br_en` at edge N: fd is a bubble after N; first request to target issued cycle N+1 (or after killed response drains).
- Reset mid-transaction: all state cleared; a late `imem_rvalid` after reset is ignored (state IDLE/REQ).

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined: `fetch_misalign` set sticky (cleared only by reset) when `br_en`=1 and `br_target`[1:0]≠0; redirect still uses aligned target.
- Not defined: `fetch_misalign` tied 0; low target bits cleared silently.

## Test plan
- Reset release, RESET_PC=0x100, memory gnt immediate, 1-cycle rvalid with data 0x00A00093 → `imem_addr` 0x100 in cycle 1; fd = {0x100, 0x00A00093, valid} in cycle 3; next request 0x104.
- `stall`=1 for 3 cycles while response 0x00208133 arrives → previous fd held, state FULL, no `imem_req`; fd = 0x00208133 the cycle after `stall` drops.
- `br_en`=1, `br_target`=0x200 while in WAIT → fd bubble, next response discarded, next `imem_addr`=0x200, no instruction from the old path reaches fd.
- `br_en` and `stall` both high same edge with buffer full → fd bubble, buffer dropped, fetch from target.
- `pc_q`=0xFFFF_FFFC granted → next `imem_addr`=0x0000_0000.
- With `FETCH_ALIGN_CHECK_EN`, `br_target`=0x202 → `fetch_misalign`=1 persisting, `imem_addr`=0x200; without macro, flag stays 0.
